bp_decim_out: RTL and testbench

Downstream stage of the bandpass IIR filter. It consumes the filter's 16-bit signed output on the same clk_en sample strobe. It performs an integrate-and-dump boxcar average over DECIM samples, with round-half-up. Averaged samples are buffered in a small FIFO and presented on a valid/ready interface to the consumer (DMA/serializer). FIFO overrun is reported through a sticky flag.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/bp_sync_fifo.sv | 81 ++++++++
 rtl/bp_decim_out.sv | 94 +++++++++
 tb/tb_bp_decim_out.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the bandpass filter chain: default sample width,
// constant log2 and the round-half-up arithmetic shift used for averaging.
package bp_pkg;

    localparam int unsigned DW_DEFAULT = 16;

    // Smallest r with 2**r >= v; usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Arithmetic shift right by l with rounding half toward +inf.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] sum,
                                                       input int unsigned       l);
        logic signed [63:0] bias;
        if (l == 0) begin
            return sum;
        end
        bias = 64'sd1 <<< (l - 1);
        return (sum + bias) >>> l;
    endfunction

endpackage

// File: rtl/bp_sync_fifo.sv
// Synchronous FIFO with a registered head word, exact level and
// registered empty/full flags. Write while full only succeeds with a read.
module bp_sync_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [clog2(DEPTH):0]    level
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW-1:0] rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic [DW-1:0] head_nxt;
    logic          do_wr;
    logic          do_rd;

    // Next-state: pointer/level update and the word that becomes the head.
    always_comb begin
        do_rd      = rd_en && !empty && !clr;
        do_wr      = wr_en && (!full || do_rd) && !clr;
        wr_ptr_nxt = do_wr ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_nxt = do_rd ? rd_ptr + AW'(1) : rd_ptr;
        level_nxt  = level + LW'(do_wr) - LW'(do_rd);
        // Bypass when the slot being written is the new head.
        if (do_wr && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = wr_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            rd_data <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            empty  <= (level_nxt == '0);
            full   <= (level_nxt == LW'(DEPTH));
            if (level_nxt != '0) begin
                rd_data <= head_nxt;
            end
        end
    end

endmodule

// File: rtl/bp_decim_out.sv
// Output stage of the bandpass filter: integrate-and-dump average over DECIM
// strobed samples, buffered in a FIFO behind a valid/ready interface.
module bp_decim_out
    import bp_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clk_en,
    input  logic signed [DW-1:0]       xin,
    input  logic                       clear,
    output logic signed [DW-1:0]       dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       overflow,
    output logic [clog2(DEPTH):0]      fifo_level
);

    localparam int unsigned L     = clog2(DECIM);
    localparam int unsigned ACC_W = DW + L;
    localparam int unsigned CW    = L;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [CW-1:0]           count;
    logic [DW-1:0]           avg;
    logic [DW-1:0]           fifo_rd_data;
    logic                    last;
    logic                    dump;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;

    // Running sum and the rounded mean produced on the dump edge.
    always_comb begin
        sum  = acc + ACC_W'(xin);
        last = (count == CW'(DECIM - 1));
        dump = clk_en && last && !clear;
        pop  = !fifo_empty && dout_ready && !clear;
        avg  = DW'(round_shift(64'(sum), L));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (clk_en) begin
            if (last) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= sum;
                count <= count + CW'(1);
            end
        end
    end

    // A dump into a full FIFO without a same-edge pop is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (dump && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    bp_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .wr_en   (dump),
        .wr_data (avg),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    assign dout       = fifo_rd_data;
    assign dout_valid = !fifo_empty;

endmodule

// File: tb/tb_bp_decim_out.sv
// Directed bench for bp_decim_out with DW=16, DECIM=4, DEPTH=4.
module tb_bp_decim_out;

    logic               clk;
    logic               reset_n;
    logic               clk_en;
    logic signed [15:0] xin;
    logic               clear;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               overflow;
    logic [2:0]         fifo_level;

    int checks;
    int errors;

    bp_decim_out #(
        .DW    (16),
        .DECIM (4),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .xin        (xin),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given strobe/sample; returns 1 time unit after the edge.
    task automatic tick(input logic en, input logic signed [15:0] x);
        clk_en = en;
        xin    = x;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        xin    = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; clk_en = 1'b0; xin = '0; dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL reset_dout got %0d exp 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        reset_n = 1'b1;
        tick(0, 0);
    endtask

    task automatic test_basic();
        dout_ready = 1'b1;
        tick(1, 1); tick(1, 2); tick(1, 2);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", dout_valid); end
        tick(1, 2);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", dout_valid); end
        checks++; if (dout !== 16'sd2) begin errors++; $display("FAIL basic_dout got %0d exp 2", dout); end
        tick(0, 0);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b exp 0", dout_valid); end
    endtask

    task automatic test_neg_rounding();
        logic signed [15:0] v [16];
        logic signed [15:0] e [4];
        v = '{-16'sd1, -16'sd2, -16'sd2, -16'sd2,
              -16'sd1, -16'sd1, -16'sd2, -16'sd2,
              -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768,
              16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
        e = '{-16'sd2, -16'sd1, -16'sd32768, 16'sd32767};
        dout_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) tick(1, v[g*4+k]);
            checks++;
            if (dout_valid !== 1'b1 || dout !== e[g]) begin
                errors++;
                $display("FAIL round_group%0d got %0d (valid %b) exp %0d", g, dout, dout_valid, e[g]);
            end
        end
        tick(0, 0);
    endtask

    task automatic test_sparse();
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 9999); tick(0, 9999);
            checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL sparse_early_valid%0d got %b exp 0", i, dout_valid); end
            tick(1, 100);
        end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL sparse_valid got %b exp 1", dout_valid); end
        checks++; if (dout !== 16'sd100) begin errors++; $display("FAIL sparse_dout got %0d exp 100", dout); end
        tick(0, 0);
    endtask

    task automatic test_overflow();
        int n;
        dout_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1, 10);
            if (i == 16) begin
                checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level_full got %0d exp 4", fifo_level); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
            end
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level_after got %0d exp 4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        dout_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (dout_valid) begin
                n++;
                checks++; if (dout !== 16'sd10) begin errors++; $display("FAIL ovf_drain_dout got %0d exp 10", dout); end
            end
            tick(0, 0);
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL ovf_drain_count got %0d exp 4", n); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drain_level got %0d exp 0", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        clear = 1'b1;
        tick(0, 0);
        clear = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_full_pop();
        logic signed [15:0] e [4];
        e = '{16'sd10, 16'sd10, 16'sd10, 16'sd20};
        dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) tick(1, 10);
        for (int i = 0; i < 3; i++) tick(1, 20);
        dout_ready = 1'b1;
        tick(1, 20);
        dout_ready = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d exp 4", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %b exp 0", overflow); end
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== e[k]) begin
                errors++;
                $display("FAIL fullpop_drain%0d got %0d (valid %b) exp %0d", k, dout, dout_valid, e[k]);
            end
            tick(0, 0);
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL fullpop_empty got %0d exp 0", fifo_level); end
    endtask

    task automatic test_clear_reset_mid();
        dout_ready = 1'b1;
        tick(1, 50); tick(1, 50);
        clear = 1'b1;
        tick(1, 50);
        clear = 1'b0;
        checks++; if (fifo_level !== 3'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL clr_state got level %0d valid %b exp 0 0", fifo_level, dout_valid); end
        tick(1, 4); tick(1, 4); tick(1, 4);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL clr_early_valid got %b exp 0", dout_valid); end
        tick(1, 4);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'sd4) begin errors++; $display("FAIL clr_dout got %0d (valid %b) exp 4", dout, dout_valid); end
        tick(0, 0);

        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick(1, 8);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL rst_pre_level got %0d exp 1", fifo_level); end
        tick(1, 50); tick(1, 50);
        reset_n = 1'b0;
        #2;
        checks++; if (fifo_level !== 3'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL rst_state got level %0d valid %b exp 0 0", fifo_level, dout_valid); end
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL rst_dout got %0d exp 0", dout); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1, 4); tick(1, 4); tick(1, 4);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_early_valid got %b exp 0", dout_valid); end
        tick(1, 4);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'sd4) begin errors++; $display("FAIL rst_dout_after got %0d (valid %b) exp 4", dout, dout_valid); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL rst_level_after got %0d exp 1", fifo_level); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_neg_rounding();
        test_sparse();
        test_overflow();
        test_full_pop();
        test_clear_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
